// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        abort;
  } fetch_entry_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetched {pc, word, abort} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         head_valid
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         pop_ok;
  logic         push_ok;

  assign head_valid = (count != 2'd0);
  assign head       = slot0;
  assign pop_ok     = pop && head_valid;
  assign push_ok    = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the pushed entry lands behind whatever remains.
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Sequential instruction fetch bus master feeding a 2-entry decode FIFO.
// Optional bus-read timeout with abort token enabled by FETCH_TIMEOUT_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic [31:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic        jmp,
  input  logic [31:0] jmppc,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic        insn_abort
);

  logic [31:0]  pc;
  logic         live;
  logic         run;
  logic         tmo_fire;
  logic         pop_raw;
  logic         pop;
  logic         push;
  logic         accept;
  logic [1:0]   count;
  logic         head_valid;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign bus_wr    = 1'b0;
  assign bus_wdata = '0;
  assign bus_addr  = pc & WORD_MASK;

  assign pop_raw = head_valid && insn_ready;
  assign pop     = pop_raw && !jmp;
  assign bus_rd  = run && !jmp && ((count != 2'd2) || pop_raw);
  assign accept  = bus_rd && bus_ready;
  assign push    = accept || tmo_fire;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = bus_addr;
    push_entry.word  = tmo_fire ? '0 : bus_rdata;
    push_entry.abort = tmo_fire;
  end

  // Holds off requests until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      pc <= RESET_PC & WORD_MASK;
    else if (jmp)    pc <= jmppc & WORD_MASK;
    else if (accept) pc <= pc + 32'd4;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned    TCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

  fetch_state_e   state;
  fetch_state_e   state_next;
  logic [TCW-1:0] tcnt;
  logic [TCW-1:0] tcnt_next;

  assign run      = live && (state == FS_RUN);
  assign tmo_fire = bus_rd && !bus_ready && (tcnt == TLAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= FS_RUN;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      tcnt  <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    if (jmp) begin
      state_next = FS_RUN;
      tcnt_next  = '0;
    end else if (tmo_fire) begin
      state_next = FS_HALT;
      tcnt_next  = '0;
    end else if (accept) begin
      tcnt_next  = '0;
    end else if (bus_rd) begin
      tcnt_next  = tcnt + 1'b1;
    end
  end

  assign insn_abort = head.abort;
`else
  assign run        = live;
  assign tmo_fire   = 1'b0;
  // Abort bit of every pushed entry is constant zero in this build.
  assign insn_abort = head.abort;
`endif

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .flush      (jmp),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .head_valid (head_valid)
  );

  assign insn       = head.word;
  assign insn_pc    = head.pc;
  assign insn_valid = head_valid;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Sequential instruction fetch stage and bus master sitting directly upstream of the on-chip block RAM. It drives the shared memory bus (`bus_addr`/`bus_rd`/`bus_ready`/`bus_rdata`), fetches word-aligned instructions starting at a reset PC, and buffers them in a 2-entry FIFO for the decode stage. Decode applies backpressure, and execute redirects fetch on a taken branch. An optional bus timeout converts a hung read, such as an unmapped address where no slave asserts ready, into an abort token.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address (word-aligned)
- `TIMEOUT`, default 16, cycles a read may wait for `bus_ready` before abort (used only with `FETCH_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_b`  in  1  reset, asynchronous, active-low
- `bus_addr`  out  32  read address, always `{pc[31:2],2'b00}`
- `bus_rd`  out  1  read request
- `bus_wr`  out  1  tied 0
- `bus_wdata`  out  32  tied 0
- `bus_rdata`  in  32  read data, valid when `bus_ready`
- `bus_ready`  in  1  slave ready for the current address
- `jmp`  in  1  redirect request
- `jmppc`  in  32  redirect target; bits [1:0] are ignored
- `insn`  out  32  head instruction word
- `insn_pc`  out  32  address of `insn`
- `insn_valid`  out  1  FIFO head valid
- `insn_ready`  in  1  decode accepts head this cycle
- `insn_abort`  out  1  head is a timeout abort token

## Operation
- FIFO: 2 entries of {pc, word, abort}. A pop occurs when `insn_valid && insn_ready`.
- Read request: `bus_rd = (state==RUN) && !jmp && (count<2 || pop)`.
- Accept: `bus_rd && bus_ready` pushes {pc, `bus_rdata`, 0}, then `pc <= pc+4`. The PC wraps from 32'hFFFF_FFFC to 0.
- Bus protocol:
  - `bus_addr` is held stable while `bus_rd` is high and `bus_ready` is low.
  - No read is ever outstanding across an address change, so dropping a request is always safe.
- `jmp` has priority over everything:
  - flush the FIFO (count=0, including a same-cycle push);
  - drop any same-cycle pop;
  - set `pc <= {jmppc[31:2],2'b00}`;
  - force state to RUN;
  - clear the timeout counter.
- States:
  - RUN: normal fetching.
  - HALT: entered only on timeout. Issues no requests. Exits only on `jmp`.
- Simultaneous push and pop with count==2: allowed. Count stays 2.
- Simultaneous push and pop with count==0: allowed. The head becomes the pushed entry next cycle; there is no bypass.

## Timing
- Reset values:
  - `pc=RESET_PC`, state RUN, count 0, timeout counter 0;
  - `bus_rd=0`, `insn_valid=0`, `insn_abort=0`, `insn=0`, `insn_pc=0`.
- `bus_rd` is a registered-state function and may rise in the first cycle after `rst_b` deasserts.
- Latency from `bus_ready` to `insn_valid`: 1 cycle.
- With the block RAM (ready one cycle after the address changes), steady-state throughput is 1 word per 2 cycles.
- `jmp` in cycle N: `bus_addr=jmppc` in cycle N+1, with `bus_rd` high in N+1. `insn_valid` is 0 in N+1.
- `insn`, `insn_pc` and `insn_abort` are stable while `insn_valid && !insn_ready`.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter increments each cycle with `bus_rd && !bus_ready` and clears on accept or `jmp`.
  - On reaching `TIMEOUT-1` with no ready, the block pushes {pc, 32'h0, 1} (this push obeys the FIFO-space rule) and enters HALT. `pc` is not advanced.
- `FETCH_TIMEOUT_EN` undefined:
  - No counter and no HALT state; reads wait indefinitely.
  - `insn_abort` is tied 0.
  - `TIMEOUT` is unused.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (`FS_RUN`, `FS_HALT`);
  - FIFO entry struct {pc, word, abort};
  - `WORD_MASK` constant 32'hFFFF_FFFC.
- One sub-module, `fetch_fifo`: a 2-entry synchronous FIFO with flush input, push/pop, count, head outputs and the same asynchronous active-low reset.

## Test plan
- Reset: hold `rst_b=0`, then release, with RAM model ready one cycle after the address changes -> `bus_addr` sequence 0,4,8, with `insn_pc` 0,4,8 and data matching memory.
- Backpressure: `insn_ready=0` after reset -> exactly 2 entries fill, then `bus_rd=0` with `bus_addr` held at 8. Raise `insn_ready` -> fetch resumes at 8.
- Redirect mid-wait: `jmp=1`, `jmppc=32'h0000_0107` while `bus_rd` is waiting -> FIFO empties, next `bus_addr=32'h104`, and the next `insn_pc` is 32'h104.
- Redirect with a full FIFO and a same-cycle pop -> no stale entry emerges, and the first valid `insn_pc` equals the target.
- PC wrap: `jmppc=32'hFFFF_FFFC` -> fetches FFFF_FFFC, then 0.
- `FETCH_TIMEOUT_EN`, `TIMEOUT=16`, `bus_ready` stuck 0 at `pc=32'h4000` -> after 16 cycles `insn_valid=1`, `insn_abort=1`, `insn_pc=32'h4000` and `bus_rd=0` until `jmp`.
